// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: accepts an operand pair, strips common factors of two,
// then reduces by halving and halved subtraction; one datapath step per clock.
module gcd_stein #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned K_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             out_valid_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [NBITS-1:0] gcd_val;
    logic             operand_zero;

    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign gcd_val      = (a_q | b_q) << k_q;
    assign operand_zero = (a_q == '0) || (b_q == '0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cycles    = cycles_q;

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            cycles_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    // Next-state and datapath step; abort takes priority over any step in flight
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cycles_d = cycles_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (operand_zero) begin
                        result_d = gcd_val;
                        cycles_d = cnt_q + CNT_W'(1);
                        state_d  = DONE;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + K_W'(1);
                    end else begin
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (operand_zero) begin
                        result_d = gcd_val;
                        cycles_d = cnt_q + CNT_W'(1);
                        state_d  = DONE;
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q >= b_q) begin
                        a_d = (a_q - b_q) >> 1;
                    end else begin
                        b_d = (b_q - a_q) >> 1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed-vector and corner-sequence bench for gcd_stein at default widths.
module tb_gcd_stein;

    localparam int unsigned NBITS = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] a_in;
    logic [NBITS-1:0] b_in;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] result;
    logic [CNT_W-1:0] cycles;

    int checks;
    int failures;

    gcd_stein #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] b;
        logic [NBITS-1:0] exp_res;
        logic [CNT_W-1:0] exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [NBITS-1:0] ref_gcd(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        logic [NBITS-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Edge count of the binary algorithm, counted step by step from the operand values
    function automatic int ref_cycles(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        logic [NBITS-1:0] x, y;
        int n;
        bit reducing;
        x = a;
        y = b;
        n = 0;
        reducing = 0;
        while (1) begin
            n++;
            if (x == 0 || y == 0) break;
            if (!reducing) begin
                if (x[0] == 0 && y[0] == 0) begin x = x / 2; y = y / 2; end
                else reducing = 1;
            end else if (x[0] == 0) x = x / 2;
            else if (y[0] == 0) y = y / 2;
            else if (x >= y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
        return n;
    endfunction

    // Accept one pair and wait (bounded) for out_valid; returns edges seen after accept
    task automatic do_op(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                         output logic [NBITS-1:0] r, output logic [CNT_W-1:0] c,
                         output int edges);
        int w;
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout: out_valid not seen for a=%0h b=%0h", a, b);
        end
        r = result;
        c = cycles;
    endtask

    vec_t vecs [10];
    logic [NBITS-1:0] r;
    logic [CNT_W-1:0] c;
    logic [NBITS-1:0] ra, rb;
    int edges;
    int seen;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        abort    = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{32'd12, 32'd18, 32'd6, 8'd6};
        vecs[1] = '{32'd48, 32'd0, 32'd48, 8'd1};
        vecs[2] = '{32'd0, 32'd0, 32'd0, 8'd1};
        vecs[3] = '{32'd0, 32'd7, 32'd7, 8'd1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 8'd34};
        vecs[5] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 8'd34};
        vecs[6] = '{32'd35, 32'd14, 32'd7, 8'd6};
        vecs[7] = '{32'd7, 32'd7, 32'd7, 8'd3};
        vecs[8] = '{32'd6, 32'd4, 32'd2, 8'd6};
        vecs[9] = '{32'd1, 32'd0, 32'd1, 8'd1};

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, r, c, edges);
            check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d_cycles", i), 64'(c), 64'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_edges", i), 64'(edges), 64'(vecs[i].exp_cyc));
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle", i), 64'({out_valid, in_ready}), 64'b01);
        end

        // Hold in DONE with out_ready low; in_valid pulses must be ignored
        out_ready = 1'b0;
        do_op(32'd12, 32'd18, r, c, edges);
        for (int i = 0; i < 5; i++) begin
            a_in = 32'd99 + 32'(i);
            b_in = 32'd3;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", i), 64'({out_valid, in_ready}), 64'b10);
            check($sformatf("hold%0d_result", i), 64'(result), 64'd6);
            check($sformatf("hold%0d_cycles", i), 64'(cycles), 64'd6);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_idle", 64'({out_valid, in_ready}), 64'b01);
        check("idle_result_kept", 64'(result), 64'd6);

        // Abort on the third edge after accepting gcd(12,18)
        do_op(32'd6, 32'd4, r, c, edges);
        @(posedge clk); #1;
        a_in = 32'd12;
        b_in = 32'd18;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", 64'({out_valid, in_ready}), 64'b01);
        check("abort_result_kept", 64'(result), 64'd2);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);

        // Abort held high in IDLE must not block the accept
        a_in = 32'd35;
        b_in = 32'd14;
        in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check("after_abort_result", 64'(result), 64'd7);
        check("after_abort_cycles", 64'(cycles), 64'd6);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of REDUCE
        a_in = 32'd12;
        b_in = 32'd18;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_cycles", 64'(cycles), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        #10;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("midrst_stays_idle", 64'(seen), 64'd0);

        // Random pairs against a Euclid reference and a step-count model
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) begin
                ra = ra & 32'h0000_FFFF;
                rb = rb & 32'h0000_FFFF;
            end
            if (i % 7 == 3) begin
                ra = ra << (i % 13);
                rb = rb << (i % 11);
            end
            do_op(ra, rb, r, c, edges);
            check("rand_result", 64'(r), 64'(ref_gcd(ra, rb)));
            check("rand_cycles", 64'(c), 64'(ref_cycles(ra, rb)));
            if (c > CNT_W'(2 * NBITS + 2)) begin
                checks++;
                failures++;
                $display("FAIL rand_latency: got %0d limit %0d", c, 2 * NBITS + 2);
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
